// File: rtl/display_timing_480p.sv
// 640x480p60 raster timing generator: registered coordinates, syncs, data enable
// and line/frame strobes, all describing the same pixel, gated by pixel-clock lock.
module display_timing_480p #(
    parameter int   CORDW  = 16,
    parameter int   H_RES  = 640,
    parameter int   H_FP   = 16,
    parameter int   H_SYNC = 96,
    parameter int   H_BP   = 48,
    parameter int   V_RES  = 480,
    parameter int   V_FP   = 10,
    parameter int   V_SYNC = 2,
    parameter int   V_BP   = 33,
    parameter logic H_POL  = 1'b0,
    parameter logic V_POL  = 1'b0
) (
    input  logic             clk_pix,
    input  logic             rst_n,
    input  logic             clk_locked,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             line,
    output logic             frame
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    localparam logic [CORDW-1:0] H_MAX      = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_MAX      = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] H_ACT      = CORDW'(H_RES);
    localparam logic [CORDW-1:0] V_ACT      = CORDW'(V_RES);
    localparam logic [CORDW-1:0] HS_START   = CORDW'(H_RES + H_FP);
    localparam logic [CORDW-1:0] HS_END     = CORDW'(H_RES + H_FP + H_SYNC);
    localparam logic [CORDW-1:0] VS_START   = CORDW'(V_RES + V_FP);
    localparam logic [CORDW-1:0] VS_END     = CORDW'(V_RES + V_FP + V_SYNC);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_run;
    logic [CORDW-1:0] w_sx_next;
    logic [CORDW-1:0] w_sy_next;
    logic             w_hs_active;
    logic             w_vs_active;

    logic [CORDW-1:0] r_sx;
    logic [CORDW-1:0] r_sy;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_de;
    logic             r_line;
    logic             r_frame;

    // Controls are decoded from the next coordinates so that every registered
    // output lines up with the registered (sx, sy) of the same cycle.
    always_comb begin
        w_state_next = IDLE;
        w_run        = 1'b0;
        w_sx_next    = '0;
        w_sy_next    = '0;
        if (clk_locked) begin
            w_state_next = RUN;
            w_run        = 1'b1;
            if (r_state == RUN) begin
                if (r_sx == H_MAX) begin
                    w_sx_next = '0;
                    w_sy_next = (r_sy == V_MAX) ? '0 : r_sy + CORDW'(1);
                end else begin
                    w_sx_next = r_sx + CORDW'(1);
                    w_sy_next = r_sy;
                end
            end
        end
    end

    assign w_hs_active = w_run && (w_sx_next >= HS_START) && (w_sx_next < HS_END);
    assign w_vs_active = w_run && (w_sy_next >= VS_START) && (w_sy_next < VS_END);

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sx    <= '0;
            r_sy    <= '0;
            r_hsync <= ~H_POL;
            r_vsync <= ~V_POL;
            r_de    <= 1'b0;
            r_line  <= 1'b0;
            r_frame <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_sx    <= w_sx_next;
            r_sy    <= w_sy_next;
            r_hsync <= w_hs_active ? H_POL : ~H_POL;
            r_vsync <= w_vs_active ? V_POL : ~V_POL;
            r_de    <= w_run && (w_sx_next < H_ACT) && (w_sy_next < V_ACT);
            r_line  <= w_run && (w_sx_next == '0);
            r_frame <= w_run && (w_sx_next == '0) && (w_sy_next == '0);
        end
    end

    assign sx    = r_sx;
    assign sy    = r_sy;
    assign hsync = r_hsync;
    assign vsync = r_vsync;
    assign de    = r_de;
    assign line  = r_line;
    assign frame = r_frame;

endmodule

// File: tb/tb_display_timing_480p.sv
// Directed bench: default-timing instance for horizontal detail, an H_POL=1 copy,
// and a scaled-down raster (80x55) so whole frames fit in a short run.
module tb_display_timing_480p;

    logic clk_pix = 1'b0;
    logic rst_n;
    logic clk_locked;

    always #5 clk_pix = ~clk_pix;

    logic [15:0] d_sx, d_sy, p_sx, p_sy, s_sx, s_sy;
    logic d_hs, d_vs, d_de, d_line, d_frame;
    logic p_hs, p_vs, p_de, p_line, p_frame;
    logic s_hs, s_vs, s_de, s_line, s_frame;

    display_timing_480p u_dut (
        .clk_pix(clk_pix), .rst_n(rst_n), .clk_locked(clk_locked),
        .sx(d_sx), .sy(d_sy), .hsync(d_hs), .vsync(d_vs),
        .de(d_de), .line(d_line), .frame(d_frame)
    );

    display_timing_480p #(.H_POL(1'b1)) u_dut_pol (
        .clk_pix(clk_pix), .rst_n(rst_n), .clk_locked(clk_locked),
        .sx(p_sx), .sy(p_sy), .hsync(p_hs), .vsync(p_vs),
        .de(p_de), .line(p_line), .frame(p_frame)
    );

    // Scaled raster: H 64+4+8+4 = 80 (hsync 68..75), V 48+2+2+3 = 55 (vsync 50..51)
    display_timing_480p #(
        .H_RES(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_RES(48), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_dut_small (
        .clk_pix(clk_pix), .rst_n(rst_n), .clk_locked(clk_locked),
        .sx(s_sx), .sy(s_sy), .hsync(s_hs), .vsync(s_vs),
        .de(s_de), .line(s_line), .frame(s_frame)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".sx"}, 32'(d_sx), 0);
        check({tag, ".sy"}, 32'(d_sy), 0);
        check({tag, ".de"}, 32'(d_de), 0);
        check({tag, ".line"}, 32'(d_line), 0);
        check({tag, ".frame"}, 32'(d_frame), 0);
        check({tag, ".hsync"}, 32'(d_hs), 1);
        check({tag, ".vsync"}, 32'(d_vs), 1);
        check({tag, ".pol_hsync"}, 32'(p_hs), 0);
        check({tag, ".small_sx"}, 32'(s_sx), 0);
    endtask

    initial begin
        int d_coord_err = 0, d_hs_err = 0, p_hs_err = 0, d_de_err = 0, d_strobe_err = 0;
        int d_hs_low = 0, d_de_cnt = 0;
        int s_frames = 0, s_frame2_at = -1, s_frame3_at = -1;
        int s_lines = 0, s_de_cnt = 0, s_hs_low = 0, s_vs_low = 0, s_de_lines = 0;
        int s_hs_err = 0, s_vs_err = 0, s_seq_err = 0, s_max_sx = 0, s_max_sy = 0;
        int prev_sx = 0, prev_sy = 0;
        int ex_sx, ex_sy;
        bit ex_hs;

        rst_n      = 1'b0;
        clk_locked = 1'b1;
        repeat (3) step();
        check_idle("reset");
        check("reset.small_vsync", 32'(s_vs), 1);

        rst_n = 1'b1;
        step();
        check("first.sx", 32'(d_sx), 0);
        check("first.sy", 32'(d_sy), 0);
        check("first.frame", 32'(d_frame), 1);
        check("first.line", 32'(d_line), 1);
        check("first.de", 32'(d_de), 1);

        for (int c = 0; c <= 8800; c++) begin
            if (c > 0) step();
            if (c < 1600) begin
                ex_sx = c % 800;
                ex_sy = c / 800;
                ex_hs = (ex_sx >= 656) && (ex_sx <= 751);
                if (32'(d_sx) != ex_sx || 32'(d_sy) != ex_sy) d_coord_err++;
                if (d_hs != !ex_hs) d_hs_err++;
                if (p_hs != ex_hs) p_hs_err++;
                if (d_de != (ex_sx < 640)) d_de_err++;
                if (d_line != (ex_sx == 0) || d_frame != (c == 0)) d_strobe_err++;
                if (c < 800 && !d_hs) d_hs_low++;
                if (c < 800 && d_de) d_de_cnt++;
                if (c == 639) check("h.de_at_639", 32'(d_de), 1);
                if (c == 640) check("h.de_at_640", 32'(d_de), 0);
                if (c == 655) check("h.hsync_at_655", 32'(d_hs), 1);
                if (c == 656) check("h.hsync_at_656", 32'(d_hs), 0);
                if (c == 751) check("h.hsync_at_751", 32'(d_hs), 0);
                if (c == 752) check("h.hsync_at_752", 32'(d_hs), 1);
                if (c == 799) check("h.sx_at_799", 32'(d_sx), 799);
                if (c == 800) begin
                    check("h.wrap_sx", 32'(d_sx), 0);
                    check("h.wrap_sy", 32'(d_sy), 1);
                    check("h.wrap_line", 32'(d_line), 1);
                end
            end

            if (s_frame) begin
                s_frames++;
                if (s_frames == 2) s_frame2_at = c;
                if (s_frames == 3) s_frame3_at = c;
            end
            if (s_hs == ((s_sx >= 68) && (s_sx <= 75))) s_hs_err++;
            if (s_vs == ((s_sy >= 50) && (s_sy <= 51))) s_vs_err++;
            if (c > 0) begin
                if (prev_sx == 79) begin
                    if (32'(s_sx) != 0 || 32'(s_sy) != ((prev_sy == 54) ? 0 : prev_sy + 1)) s_seq_err++;
                end else if (32'(s_sx) != prev_sx + 1 || 32'(s_sy) != prev_sy) begin
                    s_seq_err++;
                end
            end
            prev_sx = 32'(s_sx);
            prev_sy = 32'(s_sy);
            if (c < 4400) begin
                if (s_line) s_lines++;
                if (s_line && s_de) s_de_lines++;
                if (s_de) s_de_cnt++;
                if (!s_hs) s_hs_low++;
                if (!s_vs) s_vs_low++;
                if (32'(s_sx) > s_max_sx) s_max_sx = 32'(s_sx);
                if (32'(s_sy) > s_max_sy) s_max_sy = 32'(s_sy);
            end
            if (c == 3999) check("v.vsync_before", 32'(s_vs), 1);
            if (c == 4000) check("v.vsync_start", 32'(s_vs), 0);
            if (c == 4159) check("v.vsync_last", 32'(s_vs), 0);
            if (c == 4160) check("v.vsync_after", 32'(s_vs), 1);
            if (c == 4399) begin
                check("v.last_sx", 32'(s_sx), 79);
                check("v.last_sy", 32'(s_sy), 54);
            end
            if (c == 4400) begin
                check("v.wrap_sx", 32'(s_sx), 0);
                check("v.wrap_sy", 32'(s_sy), 0);
                check("v.wrap_frame", 32'(s_frame), 1);
            end
        end

        check("h.coord_errors", d_coord_err, 0);
        check("h.hsync_errors", d_hs_err, 0);
        check("h.pol_hsync_errors", p_hs_err, 0);
        check("h.de_errors", d_de_err, 0);
        check("h.strobe_errors", d_strobe_err, 0);
        check("h.hsync_low_cycles", d_hs_low, 96);
        check("h.de_cycles_per_line", d_de_cnt, 640);
        check("s.frame2_at", s_frame2_at, 4400);
        check("s.frame3_at", s_frame3_at, 8800);
        check("s.lines_per_frame", s_lines, 55);
        check("s.de_lines", s_de_lines, 48);
        check("s.de_cycles", s_de_cnt, 3072);
        check("s.hsync_low", s_hs_low, 440);
        check("s.vsync_low", s_vs_low, 160);
        check("s.hsync_errors", s_hs_err, 0);
        check("s.vsync_errors", s_vs_err, 0);
        check("s.sequence_errors", s_seq_err, 0);
        check("s.max_sx", s_max_sx, 79);
        check("s.max_sy", s_max_sy, 54);

        // Default instance now at (0,11); advance to sx=300 and drop lock.
        repeat (300) step();
        check("lock.pre_sx", 32'(d_sx), 300);
        check("lock.pre_sy", 32'(d_sy), 11);
        clk_locked = 1'b0;
        step();
        check_idle("unlock");
        repeat (50) step();
        check_idle("unlock_hold");
        clk_locked = 1'b1;
        step();
        check("relock.sx", 32'(d_sx), 0);
        check("relock.sy", 32'(d_sy), 0);
        check("relock.frame", 32'(d_frame), 1);
        check("relock.line", 32'(d_line), 1);
        check("relock.de", 32'(d_de), 1);
        check("relock.small_frame", 32'(s_frame), 1);
        step();
        check("relock.next_sx", 32'(d_sx), 1);

        repeat (699) step();
        check("arst.pre_sx", 32'(d_sx), 700);
        check("arst.pre_hsync", 32'(d_hs), 0);
        check("arst.pre_pol_hsync", 32'(p_hs), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.sx", 32'(d_sx), 0);
        check("arst.hsync", 32'(d_hs), 1);
        check("arst.pol_hsync", 32'(p_hs), 0);
        check("arst.frame", 32'(d_frame), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/display_timing_480p.md
Name: display_timing_480p

Overview:
- Generates 640x480p60 video timing from the pixel clock produced by the team's PLL clock generator, downstream of that clock's lock indication.
- Produces registered screen coordinates, sync pulses, data-enable and frame/line strobes for the pixel pipeline and the display output stage.
- Counting is held off until the pixel clock is reported locked, so no partial or garbled frame reaches the monitor.

Parameters:
- CORDW, 16, width of the sx/sy coordinate outputs; must satisfy 2^CORDW > H_TOTAL and 2^CORDW > V_TOTAL.
- H_RES, 640, active pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_RES, 480, active lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.
- H_POL, 0, hsync asserted level (0 = active-low).
- V_POL, 0, vsync asserted level (0 = active-low).
- Derived: H_TOTAL = H_RES+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_RES+V_FP+V_SYNC+V_BP = 525.

Ports:
- clk_pix  input  1  pixel clock; the only clock in the block.
- rst_n  input  1  reset, asynchronous, active-low.
- clk_locked  input  1  pixel clock locked, already synchronised to clk_pix; acts as the enable.
- sx  output  CORDW  horizontal coordinate of the current pixel.
- sy  output  CORDW  vertical coordinate of the current pixel.
- hsync  output  1  horizontal sync, at H_POL level when asserted.
- vsync  output  1  vertical sync, at V_POL level when asserted.
- de  output  1  data enable; high during the active picture area.
- line  output  1  one-cycle strobe at the start of every line (sx == 0).
- frame  output  1  one-cycle strobe at the start of every frame (sx == 0 and sy == 0).

Behaviour:
- All outputs are registered, and all outputs in a given cycle describe the same (sx, sy) pixel; there is no skew between coordinates and control signals.
- Reset (rst_n low, asynchronous): sx = 0, sy = 0, de = 0, line = 0, frame = 0, hsync = ~H_POL, vsync = ~V_POL. Release is sampled on a clk_pix edge.
- Two states:
  - IDLE (entered after reset, or whenever clk_locked = 0): outputs held at their reset values.
  - RUN (clk_locked = 1):
    - The first RUN cycle after IDLE presents sx = 0, sy = 0, line = 1, frame = 1, de = 1.
    - Each subsequent cycle, sx increments.
    - When sx = H_TOTAL-1, the next cycle has sx = 0 and sy increments.
    - When sx = H_TOTAL-1 and sy = V_TOTAL-1, the next cycle has sx = 0 and sy = 0; coordinates never exceed H_TOTAL-1 or V_TOTAL-1.
- clk_locked falling in RUN: the next cycle returns to IDLE values. This is an abandoned frame, with no completion.
- clk_locked rising again: a fresh frame starts at (0,0) as described above. No resume from the old position.
- de = (sx < H_RES) && (sy < V_RES).
- hsync asserted iff H_RES+H_FP <= sx < H_RES+H_FP+H_SYNC, i.e. 656..751 at default parameters.
- vsync asserted iff V_RES+V_FP <= sy < V_RES+V_FP+V_SYNC, i.e. 490..491 at default parameters. vsync is a full-line signal and changes at sx = 0.
- line = (sx == 0); frame = (sx == 0 && sy == 0). Both are 0 in IDLE.
- Comparisons are unsigned at CORDW width. Parameter sums are computed as integers at elaboration.

Test Plan:
- Hold rst_n = 0 with clk_locked = 1 -> sx = 0, sy = 0, de = 0, hsync = 1, vsync = 1, frame = 0. Release with clk_locked = 1 -> the first edge gives sx = 0, sy = 0, frame = 1, line = 1, de = 1.
- Run 2 full frames -> frame period is exactly 420000 cycles; line period is 800 cycles; each line has 640 de-high cycles; 480 lines per frame contain de.
- Within one line -> hsync is low exactly for sx 656..751 (96 cycles). de falls at the transition 639 -> 640. The transition 799 -> 0 increments sy.
- Vertical boundary -> vsync is low for sy 490..491 (1600 cycles). sy wraps 524 -> 0 with frame = 1 on that cycle.
- Drop clk_locked at sx = 300, sy = 200 -> the next cycle shows IDLE values. Raise clk_locked after 50 cycles -> the next cycle shows (0,0) with frame = 1.
- Assert rst_n = 0 between clock edges at sx = 700 (hsync low) -> hsync = 1 and sx = 0 immediately, without waiting for a clock edge. Parameter run with H_POL = 1 -> hsync is high only within 656..751.
